// File: rtl/ctrl_pipe_hazard.sv
// EX/MEM/WB control pipeline for the decoded control word: load-use bubble
// insertion, ALU operand forwarding selects and a saturating stall counter.
module ctrl_pipe_hazard #(
  parameter int CW_W  = 22,
  parameter int RN_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CW_W-1:0]  id_ctrl,
  input  logic [RN_W-1:0]  id_rs,
  input  logic [RN_W-1:0]  id_rt,
  input  logic [RN_W-1:0]  id_rd,
  input  logic             ex_flush,
  output logic             hazard_stall,
  output logic [CW_W-1:0]  ex_ctrl,
  output logic [RN_W-1:0]  ex_rd,
  output logic [8:0]       mem_ctrl,
  output logic [RN_W-1:0]  mem_rd,
  output logic             wb_load,
  output logic             wb_rf_enable,
  output logic [RN_W-1:0]  wb_rd,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  logic [CW_W-1:0]  r_ex_ctrl;
  logic [RN_W-1:0]  r_ex_rd;
  logic [8:0]       r_mem_ctrl;
  logic [RN_W-1:0]  r_mem_rd;
  logic             r_wb_load;
  logic             r_wb_rf;
  logic [RN_W-1:0]  r_wb_rd;
  logic [CNT_W-1:0] r_cnt;

  logic             w_hazard;
  logic             w_ex_fwd_ok;
  logic             w_mem_fwd_ok;
  logic             w_wb_fwd_ok;
  logic [8:0]       w_mem_next;

  assign w_hazard = r_ex_ctrl[10] & r_ex_ctrl[9] & (r_ex_rd != '0) &
                    ((r_ex_rd == id_rs) | (r_ex_rd == id_rt));

  // Loads in EX never forward; their data is not ready until MEM.
  assign w_ex_fwd_ok  = r_ex_ctrl[9] & (r_ex_rd != '0) & ~r_ex_ctrl[10];
  assign w_mem_fwd_ok = r_mem_ctrl[6] & (r_mem_rd != '0);
  assign w_wb_fwd_ok  = r_wb_rf & (r_wb_rd != '0);

  // {r31, load, rf_en, size[1:0], rw, se, mem_en, hi}; rf_en dropped for r0.
  assign w_mem_next = {r_ex_ctrl[20], r_ex_ctrl[10], r_ex_ctrl[9] & (r_ex_rd != '0),
                       r_ex_ctrl[6:5], r_ex_ctrl[4], r_ex_ctrl[3], r_ex_ctrl[0],
                       r_ex_ctrl[2]};

  function automatic logic [1:0] fwd_sel(input logic [RN_W-1:0] src);
    if (w_ex_fwd_ok && r_ex_rd == src)        fwd_sel = 2'b01;
    else if (w_mem_fwd_ok && r_mem_rd == src) fwd_sel = 2'b10;
    else if (w_wb_fwd_ok && r_wb_rd == src)   fwd_sel = 2'b11;
    else                                      fwd_sel = 2'b00;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_ctrl  <= '0;
      r_ex_rd    <= '0;
      r_mem_ctrl <= '0;
      r_mem_rd   <= '0;
      r_wb_load  <= 1'b0;
      r_wb_rf    <= 1'b0;
      r_wb_rd    <= '0;
      r_cnt      <= '0;
    end else begin
      if (ex_flush || w_hazard) begin
        r_ex_ctrl <= '0;
        r_ex_rd   <= '0;
      end else begin
        r_ex_ctrl <= id_ctrl;
        r_ex_rd   <= id_rd;
      end
      r_mem_ctrl <= w_mem_next;
      r_mem_rd   <= r_ex_rd;
      r_wb_load  <= r_mem_ctrl[7];
      r_wb_rf    <= r_mem_ctrl[6];
      r_wb_rd    <= r_mem_rd;
      if (w_hazard && !ex_flush && !(&r_cnt))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign hazard_stall = w_hazard;
  assign ex_ctrl      = r_ex_ctrl;
  assign ex_rd        = r_ex_rd;
  assign mem_ctrl     = r_mem_ctrl;
  assign mem_rd       = r_mem_rd;
  assign wb_load      = r_wb_load;
  assign wb_rf_enable = w_wb_fwd_ok;
  assign wb_rd        = r_wb_rd;
  assign fwd_a        = fwd_sel(id_rs);
  assign fwd_b        = fwd_sel(id_rt);
  assign stall_count  = r_cnt;

endmodule
